// File: rtl/alu_nibble_sequencer_if.sv
// Bus between a requester, the nibble sequencer and one external 4-bit ALU
// slice. Equal_all exists only when ALU_SEQ_EQUAL_EN is defined.
interface alu_nibble_sequencer_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    // requester side
    logic         Start;
    logic [3:0]   Select;
    logic         Mode;
    logic         Carry_in;
    logic [W-1:0] A_bar;
    logic [W-1:0] B_bar;
    logic         Busy;
    logic         Done;
    logic [W-1:0] Result_bar;
    logic         C_out_final;
`ifdef ALU_SEQ_EQUAL_EN
    logic         Equal_all;
`endif

    // ALU slice side
    logic [3:0]   Alu_A_bar;
    logic [3:0]   Alu_B_bar;
    logic [3:0]   Alu_Select;
    logic         Alu_Mode;
    logic         Alu_C_in;
    logic [3:0]   Alu_F_bar;
    logic         Alu_C_out;
    logic         Alu_Equal;

    // requester and ALU slice together
    modport master (
`ifdef ALU_SEQ_EQUAL_EN
        input  Equal_all,
`endif
        output Start, Select, Mode, Carry_in, A_bar, B_bar,
        output Alu_F_bar, Alu_C_out, Alu_Equal,
        input  Busy, Done, Result_bar, C_out_final,
        input  Alu_A_bar, Alu_B_bar, Alu_Select, Alu_Mode, Alu_C_in
    );

    // the sequencer
    modport slave (
`ifdef ALU_SEQ_EQUAL_EN
        output Equal_all,
`endif
        input  Start, Select, Mode, Carry_in, A_bar, B_bar,
        input  Alu_F_bar, Alu_C_out, Alu_Equal,
        output Busy, Done, Result_bar, C_out_final,
        output Alu_A_bar, Alu_B_bar, Alu_Select, Alu_Mode, Alu_C_in
    );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Serial controller for one 4-bit ALU slice: runs a NIBBLES*4-bit operation
// one nibble per clock, chaining the carry through a register.
// Optional feature macro: ALU_SEQ_EQUAL_EN builds the Equal_all accumulator.
module alu_nibble_sequencer #(
    parameter int NIBBLES    = 4,
    parameter int DELAY_RISE = 0,
    parameter int DELAY_FALL = 0
) (
    input  logic                  Clk,
    input  logic                  Clear_bar,
    alu_nibble_sequencer_if.slave bus
);
    localparam int            KW     = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIBBLES - 1);

    // Output delays belong to a timing model; this netlist has none.
    if (DELAY_RISE != 0 || DELAY_FALL != 0) begin : g_delay_unmodelled
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                  state, state_nx;
    logic [KW-1:0]           k;
    logic [NIBBLES-1:0][3:0] a_q, b_q, res_q;
    logic [3:0]              sel_q;
    logic                    mode_q, carry_q, cout_q;
    logic                    accept, last, busy, done;

    assign last = (k == K_LAST);

    // State register
    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) state <= S_IDLE;
        else            state <= state_nx;
    end

    // Next state, Start acceptance and status outputs
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.Start) begin
                    accept   = 1'b1;
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) state_nx = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (bus.Start) begin
                    accept   = 1'b1;
                    state_nx = S_RUN;
                end else begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Operand latch, nibble index, carry chain and result capture.
    // Result_bar is not cleared on acceptance; nibbles are overwritten in turn.
    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            k       <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 4'b0000;
            mode_q  <= 1'b0;
            carry_q <= 1'b1;
            res_q   <= '0;
            cout_q  <= 1'b1;
        end else if (accept) begin
            k       <= '0;
            a_q     <= bus.A_bar;
            b_q     <= bus.B_bar;
            sel_q   <= bus.Select;
            mode_q  <= bus.Mode;
            carry_q <= bus.Carry_in;
        end else if (state == S_RUN) begin
            res_q[k] <= bus.Alu_F_bar;
            // logic mode keeps the latched Carry_in on the slice
            if (!mode_q) carry_q <= bus.Alu_C_out;
            if (last) cout_q <= bus.Alu_C_out;
            else      k      <= k + 1'b1;
        end
    end

`ifdef ALU_SEQ_EQUAL_EN
    logic eq_acc, eq_all_q;

    // Running AND of the slice Equal output, published after the last nibble
    always_ff @(posedge Clk or negedge Clear_bar) begin
        if (!Clear_bar) begin
            eq_acc   <= 1'b1;
            eq_all_q <= 1'b0;
        end else if (accept) begin
            eq_acc <= 1'b1;
        end else if (state == S_RUN) begin
            eq_acc <= eq_acc & bus.Alu_Equal;
            if (last) eq_all_q <= eq_acc & bus.Alu_Equal;
        end
    end

    assign bus.Equal_all = eq_all_q;
`endif

    // Slice inputs come only from registers, never from the slice outputs.
    assign bus.Alu_A_bar   = a_q[k];
    assign bus.Alu_B_bar   = b_q[k];
    assign bus.Alu_Select  = sel_q;
    assign bus.Alu_Mode    = mode_q;
    assign bus.Alu_C_in    = carry_q;
    assign bus.Busy        = busy;
    assign bus.Done        = done;
    assign bus.Result_bar  = res_q;
    assign bus.C_out_final = cout_q;
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Bench for alu_nibble_sequencer: a small active-low 74181 slice model feeds
// the sequencer; directed vectors carry hand-computed wide results.
module tb_alu_nibble_sequencer;
    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic Clk = 1'b0;
    logic Clear_bar;
    int   total = 0;
    int   bad   = 0;
    int   overlap = 0;

    alu_nibble_sequencer_if #(.NIBBLES(NIBBLES)) bus();

    alu_nibble_sequencer #(.NIBBLES(NIBBLES), .DELAY_RISE(0), .DELAY_FALL(0)) dut (
        .Clk       (Clk),
        .Clear_bar (Clear_bar),
        .bus       (bus)
    );

    always #5 Clk = ~Clk;

    // Slice model, active-low data: 1001/M0 add, 0110/M0 A-B-1, 0110/M1 xor
    logic [4:0] sum;
    logic [3:0] sl_f;
    logic       sl_co;
    always_comb begin
        sum   = 5'd0;
        sl_f  = bus.Alu_A_bar;
        sl_co = 1'b1;
        if (!bus.Alu_Mode) begin
            if (bus.Alu_Select == 4'b1001)
                sum = {1'b0, bus.Alu_A_bar} + {1'b0, bus.Alu_B_bar} + {4'b0, ~bus.Alu_C_in};
            else if (bus.Alu_Select == 4'b0110)
                sum = {1'b0, bus.Alu_A_bar} + {1'b0, ~bus.Alu_B_bar} + {4'b0, ~bus.Alu_C_in};
            else
                sum = {1'b0, bus.Alu_A_bar};
            sl_f  = sum[3:0];
            sl_co = ~sum[4];
        end else if (bus.Alu_Select == 4'b0110) begin
            sl_f = bus.Alu_A_bar ^ bus.Alu_B_bar;
        end
    end
    assign bus.Alu_F_bar = sl_f;
    assign bus.Alu_C_out = sl_co;
    assign bus.Alu_Equal = &sl_f;

    always @(negedge Clk) if (bus.Busy && bus.Done) overlap++;

    typedef struct {
        logic [3:0]         sel;
        logic               mode;
        logic               cin;
        logic [W-1:0]       a;
        logic [W-1:0]       b;
        logic [W-1:0]       res;
        logic               co;
        logic               eq;
        logic [NIBBLES-1:0] ctr;   // Alu_C_in seen on each nibble
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.Select   = v.sel;
        bus.Mode     = v.mode;
        bus.Carry_in = v.cin;
        bus.A_bar    = v.a;
        bus.B_bar    = v.b;
    endtask

    // Issue one op and wait (bounded) for Done; lat counts edges E0..Done.
    task automatic run_op(input vec_t v, output logic [W-1:0] res, output logic co,
                          output logic eq, output int lat, output logic [NIBBLES-1:0] ctr);
        int n;
        @(negedge Clk);
        drive(v);
        bus.Start = 1'b1;
        lat = 0;
        n   = 0;
        ctr = '0;
        while (lat < 20) begin
            @(negedge Clk);
            bus.Start = 1'b0;
            lat++;
            if (bus.Done) break;
            if (bus.Busy && n < NIBBLES) begin
                ctr[n] = bus.Alu_C_in;
                n++;
            end
        end
        res = bus.Result_bar;
        co  = bus.C_out_final;
`ifdef ALU_SEQ_EQUAL_EN
        eq  = bus.Equal_all;
`else
        eq  = 1'b0;
`endif
    endtask

    initial begin
        logic [W-1:0]       r;
        logic               co, eq;
        int                 lat, dcount, first, second;
        logic [NIBBLES-1:0] ctr;

        vt[0] = '{4'b1001, 1'b0, 1'b1, 16'h1234, 16'h0FFF, 16'h2233, 1'b1, 1'b0, 4'b0001};
        vt[1] = '{4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 4'b0001};
        vt[2] = '{4'b0110, 1'b0, 1'b1, 16'h5555, 16'h5555, 16'hFFFF, 1'b1, 1'b1, 4'b1111};
        vt[3] = '{4'b0110, 1'b0, 1'b1, 16'h5555, 16'h5554, 16'h0000, 1'b0, 1'b0, 4'b0001};
        vt[4] = '{4'b0110, 1'b1, 1'b1, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b1, 1'b0, 4'b1111};
        vt[5] = '{4'b1001, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001, 1'b1, 1'b0, 4'b1110};
        vt[6] = '{4'b1001, 1'b0, 1'b1, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0, 4'b1111};
        vt[7] = '{4'b0110, 1'b1, 1'b1, 16'hAAAA, 16'h5555, 16'hFFFF, 1'b1, 1'b1, 4'b1111};

        // reset state
        Clear_bar = 1'b0;
        bus.Start = 1'b0;
        drive(vt[1]);
        #12;
        chk("rst busy", bus.Busy, 0);
        chk("rst done", bus.Done, 0);
        chk("rst result", bus.Result_bar, 0);
        chk("rst cout", bus.C_out_final, 1);
        chk("rst alu_cin", bus.Alu_C_in, 1);
        chk("rst alu_sel", bus.Alu_Select, 0);
        chk("rst alu_a", bus.Alu_A_bar, 0);
`ifdef ALU_SEQ_EQUAL_EN
        chk("rst equal_all", bus.Equal_all, 0);
`endif
        @(negedge Clk);
        Clear_bar = 1'b1;

        // table-driven operations
        for (int i = 0; i < 8; i++) begin
            run_op(vt[i], r, co, eq, lat, ctr);
            chk($sformatf("v%0d latency", i), lat, NIBBLES + 1);
            chk($sformatf("v%0d result", i), r, vt[i].res);
            chk($sformatf("v%0d cout", i), co, vt[i].co);
            chk($sformatf("v%0d carry_trace", i), ctr, vt[i].ctr);
`ifdef ALU_SEQ_EQUAL_EN
            chk($sformatf("v%0d equal_all", i), eq, vt[i].eq);
`endif
        end

        // Start during RUN is ignored: one Done, first result kept
        @(negedge Clk);
        drive(vt[0]);
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        @(negedge Clk);
        bus.A_bar = 16'h0000;
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        dcount = 0;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            if (bus.Done) begin
                dcount++;
                r = bus.Result_bar;
            end
        end
        chk("ignore done_count", dcount, 1);
        chk("ignore result", r, 16'h2233);

        // Start held through DONE: re-accepted at once, Done pulses 5 apart
        @(negedge Clk);
        drive(vt[0]);
        bus.Start = 1'b1;
        first  = -1;
        second = -1;
        for (int i = 0; i < 20 && second < 0; i++) begin
            @(negedge Clk);
            if (bus.Done) begin
                if (first < 0) begin
                    first = i;
                    chk("b2b first result", bus.Result_bar, 16'h2233);
                    drive(vt[1]);
                end else begin
                    second = i;
                    bus.Start = 1'b0;
                end
            end
        end
        bus.Start = 1'b0;
        chk("b2b spacing", second - first, NIBBLES + 1);
        chk("b2b second result", bus.Result_bar, 16'h0000);
        chk("b2b second cout", bus.C_out_final, 0);
        @(negedge Clk);
        chk("hold done low", bus.Done, 0);
        chk("hold result", bus.Result_bar, 16'h0000);

        // reset after two captured nibbles
        @(negedge Clk);
        drive(vt[0]);
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("mid partial", bus.Result_bar[7:0], 8'h33);
        chk("mid busy", bus.Busy, 1);
        Clear_bar = 1'b0;
        #1;
        chk("mid rst busy", bus.Busy, 0);
        chk("mid rst done", bus.Done, 0);
        chk("mid rst result", bus.Result_bar, 0);
        chk("mid rst cout", bus.C_out_final, 1);
        @(negedge Clk);
        Clear_bar = 1'b1;
        run_op(vt[0], r, co, eq, lat, ctr);
        chk("post rst latency", lat, NIBBLES + 1);
        chk("post rst result", r, 16'h2233);
        chk("post rst cout", co, 1);

        chk("busy_done overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
